// File: rtl/tff_ctrl.sv
// Sequencer for one time flip-flop (ring-oscillator storage) cell: turns a write value
// into a WE pulse of that many cycles and measures the RE-to-out delay on read.
module tff_ctrl #(
  parameter int W           = 4,
  parameter int RD_W        = W + 2,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 2,
  parameter int MAX_READ    = 2**(W+2) - 1
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [W-1:0]    wr_data,
  input  logic            rd_req,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [RD_W-1:0] rd_data,
  output logic            rd_err,
  output logic            full,
  output logic            cell_we,
  output logic            cell_re,
  output logic            cell_rstb,
  input  logic            cell_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [RD_W-1:0] CNT_ONE  = RD_W'(1);
  localparam logic [RD_W-1:0] CLR_LIM  = RD_W'(CLR_CYCLES);
  localparam logic [RD_W-1:0] MAX_LIM  = RD_W'(MAX_READ);
  localparam logic [RD_W-1:0] SYNC_OFF = RD_W'(SYNC_STAGES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RD_W-1:0]   r_cnt;
  logic [RD_W-1:0]   w_cnt_nxt;
  logic [W-1:0]      r_wdata;
  logic [W-1:0]      w_wdata_nxt;
  logic [RD_W-1:0]   r_rd_data;
  logic [RD_W-1:0]   w_rd_data_nxt;
  logic              r_rd_err;
  logic              w_rd_err_nxt;
  logic              r_wr_ready;
  logic              r_rd_ready;
  logic              r_rd_valid;
  logic              r_full;
  logic              r_cell_we;
  logic              r_cell_re;
  logic              r_cell_rstb;
  logic [SYNC_STAGES-1:0] r_sync;
  logic              r_sync_prev;
  logic              w_event;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // cell_out synchroniser plus one extra flop of the last stage for rising-edge detection
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync      <= {SYNC_STAGES{1'b0}};
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], cell_out};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_event  = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  assign w_wr_acc = wr_valid & r_wr_ready;
  assign w_rd_acc = rd_req & r_rd_ready;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_cnt     <= {RD_W{1'b0}};
      r_wdata   <= {W{1'b0}};
      r_rd_data <= {RD_W{1'b0}};
      r_rd_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_rd_err  <= w_rd_err_nxt;
    end
  end

  // Next-state, counter and read-result logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wdata_nxt   = r_wdata;
    w_rd_data_nxt = r_rd_data;
    w_rd_err_nxt  = r_rd_err;
    case (r_state)
      S_IDLE: begin
        if (w_wr_acc) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = CNT_ONE;
          w_wdata_nxt = wr_data;
        end else if (w_rd_acc) begin
          w_state_nxt   = S_ERR;
          w_rd_data_nxt = {RD_W{1'b0}};
          w_rd_err_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (r_cnt >= CLR_LIM) begin
          if (r_wdata == {W{1'b0}}) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_WRITE;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WRITE: begin
        if (r_cnt >= {{(RD_W-W){1'b0}}, r_wdata}) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        // A simultaneous read takes priority over an overwrite
        if (w_rd_acc) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = CNT_ONE;
        end else if (w_wr_acc) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = CNT_ONE;
          w_wdata_nxt = wr_data;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_READ: begin
        // The count includes the synchroniser latency, which is removed here
        if (w_event) begin
          w_state_nxt   = S_DONE;
          w_rd_data_nxt = (r_cnt > SYNC_OFF) ? (r_cnt - SYNC_OFF) : {RD_W{1'b0}};
          w_rd_err_nxt  = 1'b0;
        end else if (r_cnt >= MAX_LIM) begin
          w_state_nxt   = S_DONE;
          w_rd_data_nxt = {RD_W{1'b1}};
          w_rd_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr_ready  <= 1'b0;
      r_rd_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_cell_we   <= 1'b0;
      r_cell_re   <= 1'b0;
      r_cell_rstb <= 1'b0;
    end else begin
      r_wr_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HOLD);
      r_rd_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HOLD);
      r_rd_valid  <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
      r_full      <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_READ);
      r_cell_we   <= (w_state_nxt == S_WRITE);
      r_cell_re   <= (w_state_nxt == S_READ);
      r_cell_rstb <= (w_state_nxt != S_CLEAR);
    end
  end

  assign wr_ready  = r_wr_ready;
  assign rd_ready  = r_rd_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_err    = r_rd_err;
  assign full      = r_full;
  assign cell_we   = r_cell_we;
  assign cell_re   = r_cell_re;
  // Cell reset must follow the system reset without waiting for a clock
  assign cell_rstb = r_cell_rstb & rstb;

endmodule

// File: tb/tb_tff_ctrl.sv
// Self-checking bench for tff_ctrl: directed vector table, corner sequences and random
// write/read traffic against a transaction-level reference model with a cell stub.
module tb_tff_ctrl;

  localparam int W    = 4;
  localparam int RD_W = 6;
  localparam int CLR  = 2;
  localparam int SYNC = 2;
  localparam int MAXR = 63;

  logic            clk = 1'b0;
  logic            rstb;
  logic            wr_valid;
  logic            wr_ready;
  logic [W-1:0]    wr_data;
  logic            rd_req;
  logic            rd_ready;
  logic            rd_valid;
  logic [RD_W-1:0] rd_data;
  logic            rd_err;
  logic            full;
  logic            cell_we;
  logic            cell_re;
  logic            cell_rstb;
  logic            cell_out = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int stub_n = 0;
  int stub_cnt = 0;
  bit stub_force = 1'b0;
  bit model_full = 1'b0;

  tff_ctrl dut (
    .clk(clk), .rstb(rstb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_req(rd_req), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .full(full), .cell_we(cell_we), .cell_re(cell_re),
    .cell_rstb(cell_rstb), .cell_out(cell_out)
  );

  always #5 clk = ~clk;

  // Cell stub: out rises during the n-th RE-high cycle; forced level models a stale high
  always @(negedge clk) begin
    if (stub_force) begin
      cell_out = 1'b1;
    end else if (!cell_re) begin
      stub_cnt = 0;
      cell_out = 1'b0;
    end else begin
      stub_cnt = stub_cnt + 1;
      if (stub_n != 0 && stub_cnt == stub_n) cell_out = 1'b1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: a read returns the number of RE cycles the cell needed, else an error code
  task automatic ref_read(input int n, input bit is_full, input bit stale,
                          output int e_data, output int e_err, output int e_re);
    if (!is_full) begin
      e_data = 0; e_err = 1; e_re = 0;
    end else if (stale || n == 0 || n + SYNC > MAXR) begin
      e_data = MAXR; e_err = 1; e_re = MAXR;
    end else begin
      e_data = n; e_err = 0; e_re = n + SYNC;
    end
  endtask

  task automatic do_write(input int v, input string tag);
    int nlow = 0;
    int nwe = 0;
    int first_full = -1;
    int k = 0;
    wr_valid = 1'b1;
    wr_data  = v[W-1:0];
    while (!wr_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_wr_accept"}, wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    for (int i = 0; i <= CLR + v; i++) begin
      if (!cell_rstb) nlow++;
      if (cell_we) nwe++;
      if (full && first_full < 0) first_full = i;
      if (i < CLR + v) @(negedge clk);
    end
    check({tag, "_clr_cycles"}, nlow, CLR);
    check({tag, "_we_cycles"}, nwe, v);
    check({tag, "_full_at"}, first_full, CLR + v);
    model_full = 1'b1;
  endtask

  task automatic do_read(input int n, input bit collide, input int e_data, input int e_err,
                         input int e_re, input string tag);
    int k = 0;
    int recnt = 0;
    int lat = -1;
    logic [RD_W-1:0] d = '0;
    logic er = 1'b0;
    logic fl = 1'b0;
    stub_n = n;
    while (!rd_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_rd_ready"}, rd_ready, 1);
    rd_req = 1'b1;
    if (collide) begin wr_valid = 1'b1; wr_data = 4'd7; end
    @(negedge clk);
    rd_req = 1'b0;
    wr_valid = 1'b0;
    if (collide) begin
      check({tag, "_collide_wr_ready"}, wr_ready, 0);
      check({tag, "_collide_cell_rstb"}, cell_rstb, 1);
    end
    for (int i = 0; i < 100; i++) begin
      if (rd_valid) begin
        lat = i; d = rd_data; er = rd_err; fl = full;
        break;
      end
      if (cell_re) recnt++;
      @(negedge clk);
    end
    check({tag, "_rd_valid_seen"}, (lat >= 0), 1);
    check({tag, "_rd_data"}, d, e_data);
    check({tag, "_rd_err"}, er, e_err);
    check({tag, "_re_cycles"}, recnt, e_re);
    check({tag, "_latency"}, lat, e_re);
    check({tag, "_full_cleared"}, fl, 0);
    @(negedge clk);
    check({tag, "_rd_valid_pulse"}, rd_valid, 0);
    check({tag, "_rd_data_held"}, rd_data, e_data);
    model_full = 1'b0;
  endtask

  typedef struct {
    int op;
    int val;
    int n;
    int e_data;
    int e_err;
    int e_re;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ed, ee, er, v, n, rcnt;
    vecs[0]  = '{0, 5,  0, 0,  0, 0};
    vecs[1]  = '{1, 0,  7, 7,  0, 9};
    vecs[2]  = '{1, 0,  5, 0,  1, 0};
    vecs[3]  = '{0, 3,  0, 0,  0, 0};
    vecs[4]  = '{1, 0,  0, 63, 1, 63};
    vecs[5]  = '{0, 1,  0, 0,  0, 0};
    vecs[6]  = '{1, 0,  1, 1,  0, 3};
    vecs[7]  = '{0, 15, 0, 0,  0, 0};
    vecs[8]  = '{1, 0,  61, 61, 0, 63};
    vecs[9]  = '{0, 0,  0, 0,  0, 0};
    vecs[10] = '{1, 0,  62, 63, 1, 63};

    rstb = 1'b0; wr_valid = 1'b0; wr_data = 4'd0; rd_req = 1'b0;
    #1;
    check("reset_outputs", {wr_ready, rd_ready, full, rd_valid, rd_err, cell_we, cell_re,
                            cell_rstb, rd_data}, 0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("post_reset_cell_rstb", cell_rstb, 1);
    check("post_reset_ready", {wr_ready, rd_ready}, 2'b11);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].op == 0) do_write(vecs[i].val, $sformatf("vec%0d", i));
      else do_read(vecs[i].n, 1'b0, vecs[i].e_data, vecs[i].e_err, vecs[i].e_re,
                   $sformatf("vec%0d", i));
    end

    // Read and write together in HOLD: read wins, then a zero write gives no WE pulse
    do_write(2, "pre_collide");
    do_read(4, 1'b1, 4, 0, 6, "collide");
    do_write(0, "zero_write");
    do_write(6, "overwrite");

    // cell_out already high before READ must not count as an event
    stub_force = 1'b1;
    repeat (4) @(negedge clk);
    do_read(3, 1'b0, 63, 1, 63, "stale_high");
    stub_force = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the third WE cycle of a 9-cycle write
    wr_valid = 1'b1; wr_data = 4'd9;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (CLR + 2) @(negedge clk);
    check("midwr_we_before", cell_we, 1);
    rstb = 1'b0;
    #1;
    check("midwr_cell_we", cell_we, 0);
    check("midwr_cell_rstb", cell_rstb, 0);
    check("midwr_full", full, 0);
    check("midwr_rd_valid", rd_valid, 0);
    @(negedge clk);
    rstb = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_valid || cell_we) rcnt++;
    end
    check("midwr_quiet_after", rcnt, 0);
    model_full = 1'b0;
    do_write(4, "after_rst");
    do_read(4, 1'b0, 4, 0, 6, "after_rst");

    // Random traffic against the reference model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom_range(0, 15);
        do_write(v, $sformatf("rnd%0d_w%0d", it, v));
      end else begin
        case ($urandom_range(0, 3))
          0: n = 0;
          1: n = $urandom_range(1, 12);
          2: n = $urandom_range(58, 63);
          default: n = $urandom_range(1, 61);
        endcase
        ref_read(n, model_full, 1'b0, ed, ee, er);
        do_read(n, 1'b0, ed, ee, er, $sformatf("rnd%0d_r%0d", it, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
